mq_byte_packer: RTL and testbench
=================================

MQ_BYTE_PACKER -- requirements
Module: mq_byte_packer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning byte FIFO depth (power of two, at least 8).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port ByteOut, input, 16, the MQ coder byte pair; [15:8] is the older byte, [7:0] the newer.
REQ-005 SHALL have port BP, input, 8, the MQ coder byte pointer; its modulo-256 increment gives the count of new bytes.
REQ-006 SHALL have port flush_out, input, 1, the MQ coder termination indication (level).
REQ-007 SHALL have port WordOut, output, 32, the packed codestream word; the first byte goes in [31:24].
REQ-008 SHALL have port WordValid, output, 1, meaning WordOut, WordBytes and WordLast are valid.
REQ-009 SHALL have port WordReady, input, 1, the downstream accept signal.
REQ-010 SHALL have port WordBytes, output, 3, the number of meaningful bytes in WordOut (0 to 4).
REQ-011 SHALL have port WordLast, output, 1, marking the final word of a codestream.
REQ-012 SHALL have port Ovf, output, 1, a sticky flag for FIFO overflow.
REQ-013 SHALL have port Err, output, 1, a sticky flag for an illegal BP step.

Function
REQ-014 SHALL compute delta = (BP - BP_prev) mod 256 every cycle, where BP_prev is the registered BP.
REQ-015 SHALL use the first cycle after reset only to load BP_prev (primed=0), pushing nothing.
REQ-016 SHALL handle delta as follows:
- delta 0: no push.
- delta 1: push ByteOut[7:0].
- delta 2: push ByteOut[15:8] then ByteOut[7:0], in the same cycle.
- delta greater than 2: no push, and set Err.
REQ-017 SHALL handle BP wrap 255->0 (delta 1) and 255->1 (delta 2) as normal increments.
REQ-018 SHALL, when FIFO free space (counted after this cycle's pop) is below delta, push no bytes that cycle and set Ovf; a partial push is forbidden.
REQ-019 SHALL complete a pushed byte within its cycle, so it is eligible for a pop on the next cycle.
REQ-020 SHALL hold and advance the output register as follows:
- Hold: while WordValid=1 and WordReady=0, WordOut, WordBytes and WordLast stay stable.
- Load: allowed when WordValid=0 or WordReady=1.
- In RUN: load when FIFO count is 4 or more; pop 4 bytes; WordBytes=4; WordLast=0.
REQ-021 SHALL implement states RUN, FLUSH and DONE; reset state is RUN.
REQ-022 SHALL transition RUN->FLUSH on a rising edge of flush_out (flush_out=1, previous 0); bytes arriving that same cycle still get pushed.
REQ-023 SHALL, in FLUSH, emit full words while the count is above 4, then emit the final word:
- Count 1 to 3: residual bytes, zero-padded in the low lanes, WordBytes equal to the count, WordLast=1.
- Count exactly 4: WordBytes=4, WordLast=1.
- Count 0 at flush entry: WordOut=0, WordBytes=0, WordLast=1.
REQ-024 SHALL go FLUSH->DONE on the handshake of the WordLast word.
REQ-025 SHALL, in DONE, ignore BP deltas without pushing and without setting Err, while still tracking BP_prev.
REQ-026 SHALL go DONE->RUN when flush_out=0; the next word starts at a word boundary.
REQ-027 SHALL hold Ovf and Err until reset, with no effect on data flow.
REQ-028 SHALL use flush_out only for its rising edge; level changes inside FLUSH are ignored.

Reset
REQ-029 SHALL, on rst=0, asynchronously force:
- Outputs: WordValid=0, WordOut=0, WordBytes=0, WordLast=0, Ovf=0, Err=0.
- State: FIFO empty, state RUN, primed=0, BP_prev=0, flush-edge register=0.
REQ-030 SHALL discard any in-flight word or FIFO contents on reset mid-operation; no partial word is emitted after reset release.

Verification
REQ-031 SHALL cover single-byte steps: BP 10->11->12->13->14 with ByteOut[7:0]=A1,A2,A3,A4 and WordReady=1 -> one word A1A2A3A4, WordBytes=4, WordLast=0, WordValid the cycle after the A4 push.
REQ-032 SHALL cover byte pairs across wrap: BP 254->0->2 with ByteOut=B1B2 then B3B4 -> word B1B2B3B4 with no Err.
REQ-033 SHALL cover a partial flush: 6 bytes C1 to C6, then a flush_out pulse -> words C1C2C3C4 (WordBytes=4, WordLast=0) and C5C60000 (WordBytes=2, WordLast=1), then DONE.
REQ-034 SHALL cover backpressure and overflow: WordReady=0 with 2 bytes per cycle pushed until full -> WordOut stable throughout, Ovf=1 at the first rejected delta, no bytes from that delta ever emitted.
REQ-035 SHALL cover an illegal step and reset: BP 20->25 -> Err=1 and no push; then rst=0 mid-word -> all outputs 0 immediately, and the first BP after release is not pushed.

Source files
------------

// File: rtl/mq_byte_packer.sv
// Packs the MQ coder's 0..2 bytes per cycle into 32-bit codestream words,
// with a flush sequence that emits a final, possibly partial, word.
module mq_byte_packer #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ByteOut,
    input  logic [7:0]  BP,
    input  logic        flush_out,
    output logic [31:0] WordOut,
    output logic        WordValid,
    input  logic        WordReady,
    output logic [2:0]  WordBytes,
    output logic        WordLast,
    output logic        Ovf,
    output logic        Err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t          state, state_next;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            primed;
    logic [7:0]      bp_prev;
    logic            flush_d;

    logic [7:0]      delta;
    logic            flush_rise;
    logic            load_ok;
    logic            do_load;
    logic            ld_last;
    logic [2:0]      ld_bytes;
    logic [2:0]      pop_n;
    logic [1:0]      push_n;
    logic [CW-1:0]   free_sp;
    logic [31:0]     ld_word;
    logic            set_err;
    logic            set_ovf;

    assign delta      = BP - bp_prev;
    assign flush_rise = flush_out & ~flush_d;
    assign load_ok    = ~WordValid | WordReady;

    // Output-side control: decides whether the word register loads and how many bytes leave the FIFO.
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        do_load    = 1'b0;
        ld_last    = 1'b0;
        ld_bytes   = 3'd0;
        pop_n      = 3'd0;
        unique case (state)
            RUN: begin
                if (flush_rise) state_next = FLUSH;
                if (load_ok && count >= CW'(4)) begin
                    do_load  = 1'b1;
                    ld_bytes = 3'd4;
                    pop_n    = 3'd4;
                end
            end
            FLUSH: begin
                if (WordValid && WordLast) begin
                    if (WordReady) state_next = DONE;
                end else if (load_ok) begin
                    do_load = 1'b1;
                    if (count > CW'(4)) begin
                        ld_bytes = 3'd4;
                        pop_n    = 3'd4;
                    end else begin
                        ld_bytes = 3'(count);
                        pop_n    = 3'(count);
                        ld_last  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (!flush_out) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // Input side: a step is pushed whole or not at all, judged against space left after this cycle's pop.
    always_comb begin
        push_n  = 2'd0;
        set_err = 1'b0;
        set_ovf = 1'b0;
        free_sp = CW'(FIFO_DEPTH) - count + CW'(pop_n);
        if (primed && state != DONE) begin
            if (delta > 8'd2) begin
                set_err = 1'b1;
            end else if (delta != 8'd0 && state == RUN) begin
                if (free_sp < CW'(delta[1:0])) set_ovf = 1'b1;
                else                           push_n  = delta[1:0];
            end
        end
    end

    // Lanes beyond the byte count stay zero, which gives the padded final word.
    always_comb begin
        ld_word = '0;
        for (int i = 0; i < 4; i++) begin
            if (3'(i) < ld_bytes) ld_word[31-8*i -: 8] = mem[rd_ptr + AW'(i)];
        end
    end

    // NOTE: the byte storage has no reset; emptiness is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push_n == 2'd2) begin
            mem[wr_ptr]          <= ByteOut[15:8];
            mem[wr_ptr + AW'(1)] <= ByteOut[7:0];
        end else if (push_n == 2'd1) begin
            mem[wr_ptr] <= ByteOut[7:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RUN;
            primed    <= 1'b0;
            bp_prev   <= 8'd0;
            flush_d   <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            WordValid <= 1'b0;
            WordOut   <= 32'd0;
            WordBytes <= 3'd0;
            WordLast  <= 1'b0;
            Ovf       <= 1'b0;
            Err       <= 1'b0;
        end else begin
            state   <= state_next;
            primed  <= 1'b1;
            bp_prev <= BP;
            flush_d <= flush_out;
            wr_ptr  <= wr_ptr + AW'(push_n);
            rd_ptr  <= rd_ptr + AW'(pop_n);
            count   <= count - CW'(pop_n) + CW'(push_n);
            if (set_err) Err <= 1'b1;
            if (set_ovf) Ovf <= 1'b1;
            if (do_load) begin
                WordValid <= 1'b1;
                WordOut   <= ld_word;
                WordBytes <= ld_bytes;
                WordLast  <= ld_last;
            end else if (WordReady) begin
                WordValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mq_byte_packer.sv
// Scoreboard bench for mq_byte_packer: a byte-queue reference model predicts
// every emitted word; a negedge monitor compares words at each handshake.
module tb_mq_byte_packer;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ByteOut = '0;
    logic [7:0]  BP = '0;
    logic        flush_out = 1'b0;
    logic        WordReady = 1'b0;
    logic [31:0] WordOut;
    logic        WordValid;
    logic [2:0]  WordBytes;
    logic        WordLast;
    logic        Ovf;
    logic        Err;

    always #5 clk = ~clk;

    mq_byte_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .ByteOut   (ByteOut),
        .BP        (BP),
        .flush_out (flush_out),
        .WordOut   (WordOut),
        .WordValid (WordValid),
        .WordReady (WordReady),
        .WordBytes (WordBytes),
        .WordLast  (WordLast),
        .Ovf       (Ovf),
        .Err       (Err)
    );

    typedef struct packed {
        logic [31:0] w;
        logic [2:0]  b;
        logic        l;
    } word_t;

    typedef enum {M_RUN, M_FLUSH, M_DONE} mstate_t;

    word_t      exp_q[$];
    logic [7:0] byte_q[$];
    mstate_t    m_state;
    bit         m_primed, m_valid, m_last, m_ovf, m_err, m_fl_prev;
    logic [7:0] m_bp_prev;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_state   = M_RUN;
        m_primed  = 0;
        m_valid   = 0;
        m_last    = 0;
        m_ovf     = 0;
        m_err     = 0;
        m_fl_prev = 0;
        m_bp_prev = 8'd0;
        exp_q.delete();
        byte_q.delete();
    endfunction

    // Take n bytes from the head of the stream, first byte in the top lane.
    function automatic void emit(input int n, input bit last);
        word_t e;
        e.w = 32'd0;
        for (int i = 0; i < n; i++) e.w[31-8*i -: 8] = byte_q.pop_front();
        e.b = 3'(n);
        e.l = last;
        exp_q.push_back(e);
        m_valid = 1;
        m_last  = last;
    endfunction

    // Predicts the effect of the coming clock edge given the inputs now driven.
    function automatic void model_step();
        mstate_t nxt;
        bit      can_load;
        int      delta;
        nxt      = m_state;
        can_load = !m_valid || WordReady;
        case (m_state)
            M_RUN: begin
                if (can_load && byte_q.size() >= 4) emit(4, 0);
                else if (WordReady) m_valid = 0;
                if (flush_out && !m_fl_prev) nxt = M_FLUSH;
            end
            M_FLUSH: begin
                if (m_valid && m_last) begin
                    if (WordReady) begin
                        m_valid = 0;
                        nxt = M_DONE;
                    end
                end else if (can_load) begin
                    if (byte_q.size() > 4) emit(4, 0);
                    else                   emit(byte_q.size(), 1);
                end
            end
            default: begin
                if (!flush_out) nxt = M_RUN;
            end
        endcase
        delta = (int'(BP) - int'(m_bp_prev) + 256) % 256;
        if (m_primed && m_state != M_DONE) begin
            if (delta > 2) begin
                m_err = 1;
            end else if (delta > 0 && m_state == M_RUN) begin
                if (DEPTH - byte_q.size() < delta) begin
                    m_ovf = 1;
                end else begin
                    if (delta == 2) byte_q.push_back(ByteOut[15:8]);
                    byte_q.push_back(ByteOut[7:0]);
                end
            end
        end
        m_primed  = 1;
        m_bp_prev = BP;
        m_fl_prev = flush_out;
        m_state   = nxt;
    endfunction

    task automatic cycle(input logic [7:0] bp, input logic [15:0] bo, input logic fl, input logic rdy);
        BP        = bp;
        ByteOut   = bo;
        flush_out = fl;
        WordReady = rdy;
        model_step();
        @(posedge clk);
        #1;
        check("ovf_flag", Ovf, m_ovf);
        check("err_flag", Err, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        check("rst_valid", WordValid, 0);
        check("rst_word",  WordOut,   0);
        check("rst_bytes", WordBytes, 0);
        check("rst_last",  WordLast,  0);
        check("rst_ovf",   Ovf,       0);
        check("rst_err",   Err,       0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: compares every handshaked word and verifies stability while stalled.
    word_t held;
    bit    hold_pending = 0;
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            hold_pending = 0;
        end else begin
            if (hold_pending) check("hold_stable", {WordOut, WordBytes, WordLast}, held);
            hold_pending = WordValid && !WordReady;
            held = {WordOut, WordBytes, WordLast};
            if (WordValid && WordReady) begin
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) check("word_data", {WordOut, WordBytes, WordLast}, exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] bp;
        logic [7:0] val;
        int         fl_cnt;
        int         r;
        int         d;

        model_reset();
        #2;
        do_reset();

        // Single-byte steps build one full word.
        cycle(8'd10, 16'h0000, 0, 1);
        cycle(8'd11, 16'h00A1, 0, 1);
        cycle(8'd12, 16'h00A2, 0, 1);
        cycle(8'd13, 16'h00A3, 0, 1);
        cycle(8'd14, 16'h00A4, 0, 1);
        check("first_word_not_yet", WordValid, 0);
        cycle(8'd14, 16'h0000, 0, 1);
        check("first_word_valid", WordValid, 1);
        repeat (3) cycle(8'd14, 16'h0000, 0, 1);

        // Byte pairs across the 255->0 wrap.
        do_reset();
        cycle(8'd254, 16'h0000, 0, 1);
        cycle(8'd0,   16'hB1B2, 0, 1);
        cycle(8'd2,   16'hB3B4, 0, 1);
        repeat (3) cycle(8'd2, 16'h0000, 0, 1);
        check("wrap_no_err", Err, 0);

        // Six bytes then a flush pulse: one full word and a 2-byte final word.
        bp = 8'd2;
        for (int i = 1; i <= 6; i++) begin
            bp++;
            cycle(bp, {8'h00, 8'hC0 + 8'(i)}, 0, 1);
        end
        cycle(bp, 16'h0000, 1, 1);
        repeat (8) cycle(bp, 16'h0000, 0, 1);

        // Backpressure until the FIFO overflows, then drain.
        do_reset();
        bp  = 8'd50;
        val = 8'h10;
        cycle(bp, 16'h0000, 0, 0);
        for (int i = 0; i < 12; i++) begin
            bp  = bp + 8'd2;
            cycle(bp, {val, val + 8'd1}, 0, 0);
            val = val + 8'd2;
        end
        check("ovf_set", Ovf, 1);
        repeat (12) cycle(bp, 16'h0000, 0, 1);

        // Randomised traffic with stalls, flush pulses and rare illegal steps.
        do_reset();
        bp     = 8'($urandom);
        fl_cnt = 0;
        cycle(bp, 16'h0000, 0, 1);
        for (int k = 0; k < 600; k++) begin
            r = $urandom_range(0, 99);
            if (r < 40)      d = 0;
            else if (r < 70) d = 1;
            else if (r < 98) d = 2;
            else             d = $urandom_range(3, 255);
            bp = bp + 8'(d);
            if (fl_cnt == 0 && $urandom_range(0, 99) < 3) fl_cnt = $urandom_range(1, 6);
            cycle(bp, 16'($urandom), fl_cnt > 0, $urandom_range(0, 9) < 7);
            if (fl_cnt > 0) fl_cnt--;
        end
        repeat (12) cycle(bp, 16'h0000, 0, 1);

        // Illegal step, then reset with a word in flight.
        do_reset();
        cycle(8'd20, 16'h0000, 0, 1);
        cycle(8'd25, 16'hEEEE, 0, 1);
        check("illegal_step_err", Err, 1);
        cycle(8'd27, 16'hF1F2, 0, 1);
        cycle(8'd29, 16'hF3F4, 0, 1);
        repeat (3) cycle(8'd29, 16'h0000, 0, 1);
        cycle(8'd31, 16'h5152, 0, 0);
        cycle(8'd33, 16'h5354, 0, 0);
        cycle(8'd33, 16'h0000, 0, 0);
        check("midword_valid", WordValid, 1);
        do_reset();
        cycle(8'd100, 16'h00D0, 0, 1);
        cycle(8'd101, 16'h00D1, 0, 1);
        cycle(8'd102, 16'h00D2, 0, 1);
        cycle(8'd103, 16'h00D3, 0, 1);
        cycle(8'd104, 16'h00D4, 0, 1);
        repeat (10) cycle(8'd104, 16'h0000, 0, 1);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
